// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared types, rate table and helpers for the SID envelope generator
// Contents:
//   adsr_state_t   2-bit ADSR state encoding
//   RATE_PERIOD    16-entry rate period table, in 1 MHz cycles
//   EXP_THR_* / EXP_DIV_*  exponential decay thresholds and divisors
//   sustain_level() nibble-to-level expansion
//   exp_divisor()   divisor selection for the exponential decay counter
package sid_pkg;

    typedef enum logic [1:0] {
        RELEASE       = 2'd0,
        ATTACK        = 2'd1,
        DECAY_SUSTAIN = 2'd2
    } adsr_state_t;

    localparam logic [14:0] RATE_PERIOD [16] = '{
        15'd9,    15'd32,   15'd63,    15'd95,
        15'd149,  15'd220,  15'd267,   15'd313,
        15'd392,  15'd977,  15'd1954,  15'd3126,
        15'd3907, 15'd11720, 15'd19532, 15'd31251
    };

    // Lower bound of each envelope band; the band selects the decay divisor.
    localparam logic [7:0] EXP_THR_1  = 8'd94;
    localparam logic [7:0] EXP_THR_2  = 8'd55;
    localparam logic [7:0] EXP_THR_4  = 8'd27;
    localparam logic [7:0] EXP_THR_8  = 8'd15;
    localparam logic [7:0] EXP_THR_16 = 8'd7;

    localparam logic [4:0] EXP_DIV_1  = 5'd1;
    localparam logic [4:0] EXP_DIV_2  = 5'd2;
    localparam logic [4:0] EXP_DIV_4  = 5'd4;
    localparam logic [4:0] EXP_DIV_8  = 5'd8;
    localparam logic [4:0] EXP_DIV_16 = 5'd16;
    localparam logic [4:0] EXP_DIV_30 = 5'd30;

    // Sustain nibble S maps to level {S,S}, so 0xF reaches full scale.
    function automatic logic [7:0] sustain_level(input logic [3:0] s);
        return {s, s};
    endfunction

    // Level 0 falls into the slowest band; it never steps in that case anyway.
    function automatic logic [4:0] exp_divisor(input logic [7:0] level);
        if (level >= EXP_THR_1)       return EXP_DIV_1;
        else if (level >= EXP_THR_2)  return EXP_DIV_2;
        else if (level >= EXP_THR_4)  return EXP_DIV_4;
        else if (level >= EXP_THR_8)  return EXP_DIV_8;
        else if (level >= EXP_THR_16) return EXP_DIV_16;
        else                          return EXP_DIV_30;
    endfunction

endpackage

// File: rtl/env_rate_cnt.sv
// rtl/env_rate_cnt.sv - 15-bit rate prescaler emitting one tick every RATE_PERIOD[rate_idx] cycles
// Ports:
//   clk       in   1  1 MHz SID clock
//   rst       in   1  synchronous reset, active-high
//   rate_idx  in   4  index into RATE_PERIOD
//   clear     in   1  restart the count from 0
//   tick      out  1  high in the cycle the count sits at period-1
module env_rate_cnt
    import sid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rate_idx,
    input  logic       clear,
    output logic       tick
);

    logic [14:0] cnt;
    logic [14:0] period_m1;

    assign period_m1 = RATE_PERIOD[rate_idx] - 15'd1;

    // Exact-match compare: if the period shrinks below the current count the
    // counter runs on to 0x7FFF and wraps silently before it can match again.
    assign tick = (cnt == period_m1);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 15'd1;
        end
    end

endmodule

// File: rtl/env_gen.sv
// rtl/env_gen.sv - ADSR envelope generator and amplitude scaler for one SID voice
// Optional feature: define ENV_EXP_DECAY_EN for exponential decay/release steps;
// without it every rate tick is a step in all states.
// Ports:
//   clk              in   1   1 MHz SID clock
//   rst              in   1   synchronous reset, active-high
//   control          in   8   voice control byte, bit 0 = gate
//   attack_decay     in   8   [7:4] attack rate, [3:0] decay rate
//   sustain_release  in   8   [7:4] sustain level, [3:0] release rate
//   wave_in          in   12  selected waveform sample
//   env_out          out  8   envelope level
//   env_state        out  2   ADSR state
//   amp_out          out  20  registered wave_in * env_out
module env_gen
    import sid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  control,
    input  logic [7:0]  attack_decay,
    input  logic [7:0]  sustain_release,
    input  logic [11:0] wave_in,
    output logic [7:0]  env_out,
    output adsr_state_t env_state,
    output logic [19:0] amp_out
);

    adsr_state_t state;
    adsr_state_t next_state;
    logic [7:0]  env;
    logic [7:0]  env_next;
    logic        gate;
    logic        gate_prev;
    logic        hist_valid;
    logic        gate_rise;
    logic        gate_fall;
    logic [3:0]  rate_idx;
    logic        rate_tick;
    logic        rate_clear;
    logic        step;
    logic [7:0]  sustain_target;
    logic        ctrl_unused;

    assign gate        = control[0];
    assign ctrl_unused = ^control[7:1];

    // gate_prev is meaningless until one post-reset cycle has loaded it, so a
    // gate already high when reset lifts is not treated as a rising edge.
    assign gate_rise = hist_valid &  gate & ~gate_prev;
    assign gate_fall = hist_valid & ~gate &  gate_prev;

    assign sustain_target = sustain_level(sustain_release[7:4]);

    always_comb begin
        rate_idx = sustain_release[3:0];
        case (state)
            ATTACK:        rate_idx = attack_decay[7:4];
            DECAY_SUSTAIN: rate_idx = attack_decay[3:0];
            default:       rate_idx = sustain_release[3:0];
        endcase
    end

    env_rate_cnt u_rate_cnt (
        .clk      (clk),
        .rst      (rst),
        .rate_idx (rate_idx),
        .clear    (rate_clear),
        .tick     (rate_tick)
    );

`ifdef ENV_EXP_DECAY_EN
    logic [4:0] exp_cnt;

    // exp_cnt counts rate ticks since the last step; the band divisor sets how
    // many ticks make one decay/release step.
    assign step = rate_tick && ((exp_cnt + 5'd1) >= exp_divisor(env));

    always_ff @(posedge clk) begin
        if (rst || rate_clear || (state == ATTACK)) begin
            exp_cnt <= '0;
        end else if (rate_tick) begin
            exp_cnt <= step ? 5'd0 : exp_cnt + 5'd1;
        end
    end
`else
    assign step = rate_tick;
`endif

    always_comb begin
        next_state = state;
        env_next   = env;
        // Gate edges take priority: a tick in the same cycle is dropped.
        if (gate_rise) begin
            next_state = ATTACK;
        end else if (gate_fall) begin
            next_state = RELEASE;
        end else begin
            case (state)
                ATTACK: begin
                    if (rate_tick) begin
                        if (env != 8'hFF) begin
                            env_next = env + 8'd1;
                        end
                        if (env >= 8'hFE) begin
                            next_state = DECAY_SUSTAIN;
                        end
                    end
                end
                DECAY_SUSTAIN: begin
                    // Only ever falls toward the target; a raised target just holds.
                    if (step && (env > sustain_target)) begin
                        env_next = env - 8'd1;
                    end
                end
                RELEASE: begin
                    if (step && (env != 8'd0)) begin
                        env_next = env - 8'd1;
                    end
                end
                default: begin
                    next_state = RELEASE;
                end
            endcase
        end
    end

    assign rate_clear = gate_rise | gate_fall | (next_state != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RELEASE;
            env        <= 8'd0;
            gate_prev  <= 1'b0;
            hist_valid <= 1'b0;
            amp_out    <= 20'd0;
        end else begin
            state      <= next_state;
            env        <= env_next;
            gate_prev  <= gate;
            hist_valid <= 1'b1;
            amp_out    <= {8'd0, wave_in} * {12'd0, env};
        end
    end

    assign env_out   = env;
    assign env_state = state;

endmodule

// File: tb/tb_env_gen.sv
// tb/tb_env_gen.sv - self-checking bench for env_gen
module tb_env_gen;
    import sid_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  control = 8'd0;
    logic [7:0]  attack_decay = 8'd0;
    logic [7:0]  sustain_release = 8'd0;
    logic [11:0] wave_in = 12'd0;
    logic [7:0]  env_out;
    adsr_state_t env_state;
    logic [19:0] amp_out;

    env_gen dut (
        .clk             (clk),
        .rst             (rst),
        .control         (control),
        .attack_decay    (attack_decay),
        .sustain_release (sustain_release),
        .wave_in         (wave_in),
        .env_out         (env_out),
        .env_state       (env_state),
        .amp_out         (amp_out)
    );

    always #5 clk = ~clk;

`ifdef ENV_EXP_DECAY_EN
    localparam int         REL_FROM_88 = 637 * 32;
    localparam int         INT_AT_60   = 18;
    localparam int         INT_AT_3    = 270;
    localparam logic [7:0] RETRIG_ENV  = 8'h40;
`else
    localparam int         REL_FROM_88 = 136 * 32;
    localparam int         INT_AT_60   = 9;
    localparam int         INT_AT_3    = 9;
    localparam logic [7:0] RETRIG_ENV  = 8'h3F;
`endif

    typedef struct { logic [3:0] atk; int first_step; } atk_vec_t;
    typedef struct { logic [11:0] wave; logic [19:0] amp; } mul_vec_t;

    int checks = 0;
    int errors = 0;

    int per_tab [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977,
                         1954, 3126, 3907, 11720, 19532, 31251};

    int          m_env, m_cnt, m_exp, m_amp;
    adsr_state_t m_state;
    bit          m_prev, m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_div(input int e);
        if (e >= 94) return 1;
        if (e >= 55) return 2;
        if (e >= 27) return 4;
        if (e >= 15) return 8;
        if (e >= 7)  return 16;
        return 30;
    endfunction

    // Behavioural model: advanced once per clock edge from the inputs the DUT sampled.
    task automatic model_edge();
        int idx, per;
        bit g, rise, fall, tick, stp;
        adsr_state_t ns;
        if (rst) begin
            m_env = 0; m_cnt = 0; m_exp = 0; m_amp = 0;
            m_state = RELEASE; m_prev = 0; m_valid = 0;
            return;
        end
        m_amp = int'(wave_in) * m_env;
        g    = control[0];
        rise = m_valid && g && !m_prev;
        fall = m_valid && !g && m_prev;
        m_prev  = g;
        m_valid = 1;
        if (rise || fall) begin
            m_state = rise ? ATTACK : RELEASE;
            m_cnt = 0;
            m_exp = 0;
            return;
        end
        if (m_state == ATTACK)             idx = int'(attack_decay[7:4]);
        else if (m_state == DECAY_SUSTAIN) idx = int'(attack_decay[3:0]);
        else                               idx = int'(sustain_release[3:0]);
        per  = per_tab[idx];
        tick = (m_cnt == per - 1);
        m_cnt = tick ? 0 : (m_cnt + 1) % 32768;
        ns = m_state;
        if (m_state == ATTACK) begin
            if (tick) begin
                if (m_env < 255) m_env++;
                if (m_env == 255) ns = DECAY_SUSTAIN;
            end
        end else begin
            stp = tick;
`ifdef ENV_EXP_DECAY_EN
            if (tick) begin
                m_exp++;
                stp = (m_exp >= exp_div(m_env));
                if (stp) m_exp = 0;
            end
`endif
            if (stp) begin
                if (m_state == DECAY_SUSTAIN) begin
                    if (m_env > 17 * int'(sustain_release[7:4])) m_env--;
                end else if (m_env > 0) begin
                    m_env--;
                end
            end
        end
        if (ns != m_state) begin
            m_state = ns;
            m_cnt = 0;
            m_exp = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (env_out !== 8'(m_env) || env_state !== m_state || amp_out !== 20'(m_amp)) begin
            errors++;
            $display("FAIL model: env %0d/%0d state %0d/%0d amp %0d/%0d",
                     env_out, m_env, env_state, m_state, amp_out, m_amp);
        end
    endtask

    task automatic wait_env(input logic [7:0] target, input int bound, output int n);
        n = 0;
        while (env_out !== target && n < bound) begin
            cycle();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        control = 8'd0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        int n;
        atk_vec_t atk_tab [4];
        mul_vec_t mul_tab [5];

        atk_tab[0] = '{4'h0, 9};
        atk_tab[1] = '{4'h1, 32};
        atk_tab[2] = '{4'h2, 63};
        atk_tab[3] = '{4'h3, 95};
        mul_tab[0] = '{12'hFFF, 20'hFEF01};
        mul_tab[1] = '{12'h000, 20'h00000};
        mul_tab[2] = '{12'h001, 20'h000FF};
        mul_tab[3] = '{12'h800, 20'h7F800};
        mul_tab[4] = '{12'h123, 20'h121DD};

        do_reset();
        check("reset_env", 32'(env_out), 32'd0);
        check("reset_state", 32'(env_state), 32'(RELEASE));
        check("reset_amp", 32'(amp_out), 32'd0);

        // First attack step lands exactly one period after the state turns ATTACK.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            attack_decay    = {atk_tab[i].atk, 4'h0};
            sustain_release = 8'hF0;
            control = 8'hFE;
            cycle();
            control = 8'h01;
            cycle();
            check("atk_state", 32'(env_state), 32'(ATTACK));
            wait_env(8'd1, 400, n);
            check("atk_first_step", n, atk_tab[i].first_step);
        end

        // Full attack, multiply at full scale, decay to sustain, release to zero.
        do_reset();
        attack_decay    = 8'h00;
        sustain_release = 8'hF0;
        control = 8'h01;
        cycle();
        wait_env(8'hFF, 3000, n);
        check("attack_len", n, 2295);
        check("attack_to_ds", 32'(env_state), 32'(DECAY_SUSTAIN));
        repeat (50) cycle();
        check("hold_ff", 32'(env_out), 32'hFF);
        for (int i = 0; i < 5; i++) begin
            wave_in = mul_tab[i].wave;
            cycle();
            check("amp_vec", 32'(amp_out), 32'(mul_tab[i].amp));
        end
        sustain_release = 8'h80;
        wait_env(8'hFE, 100, n);
        wait_env(8'h88, 2000, n);
        check("decay_len", n, 118 * 9);
        repeat (200) cycle();
        check("sustain_hold", 32'(env_out), 32'h88);
        sustain_release = 8'hC0;
        repeat (100) cycle();
        check("target_raised", 32'(env_out), 32'h88);
        sustain_release = 8'h81;
        control = 8'h00;
        cycle();
        check("rel_state", 32'(env_state), 32'(RELEASE));
        wait_env(8'd0, 25000, n);
        check("release_len", n, REL_FROM_88);
        repeat (100) cycle();
        check("rel_hold_zero", 32'(env_out), 32'd0);
        check("rel_hold_state", 32'(env_state), 32'(RELEASE));

        // Release step intervals at several envelope levels.
        do_reset();
        attack_decay    = 8'h00;
        sustain_release = 8'hF0;
        control = 8'h01;
        cycle();
        wait_env(8'hFF, 3000, n);
        control = 8'h00;
        cycle();
        wait_env(8'hFE, 50, n);
        check("rel_first_int", n, 9);
        wait_env(8'd60, 3000, n);
        wait_env(8'd59, 400, n);
        check("rel_int_60", n, INT_AT_60);
        wait_env(8'd3, 6000, n);
        wait_env(8'd2, 400, n);
        check("rel_int_3", n, INT_AT_3);

        // Retrigger from a nonzero level, then a gate edge coinciding with a tick.
        do_reset();
        attack_decay    = 8'h03;
        sustain_release = 8'hF3;
        control = 8'h01;
        cycle();
        wait_env(8'h40, 1000, n);
        control = 8'h00;
        cycle();
        repeat (99) cycle();
        control = 8'h01;
        cycle();
        check("retrig_env", 32'(env_out), 32'(RETRIG_ENV));
        check("retrig_state", 32'(env_state), 32'(ATTACK));
        repeat (8) cycle();
        check("pre_tick_env", 32'(env_out), 32'(RETRIG_ENV));
        control = 8'h00;
        cycle();
        check("edge_vs_tick_env", 32'(env_out), 32'(RETRIG_ENV));
        check("edge_vs_tick_state", 32'(env_state), 32'(RELEASE));

        // Reset in the middle of an attack, gate held high through release of reset.
        do_reset();
        attack_decay = 8'h00;
        control = 8'h01;
        cycle();
        repeat (50) cycle();
        wave_in = 12'hFFF;
        cycle();
        rst = 1'b1;
        cycle();
        check("midrst_env", 32'(env_out), 32'd0);
        check("midrst_amp", 32'(amp_out), 32'd0);
        check("midrst_state", 32'(env_state), 32'(RELEASE));
        rst = 1'b0;
        repeat (20) cycle();
        check("post_rst_state", 32'(env_state), 32'(RELEASE));
        check("post_rst_env", 32'(env_out), 32'd0);

        // Randomised run against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 150) == 0) control[0] = ~control[0];
            control[7:1] = 7'($urandom);
            if ($urandom_range(0, 400) == 0)
                attack_decay = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
            if ($urandom_range(0, 400) == 0)
                sustain_release = {4'($urandom), 4'($urandom_range(0, 4))};
            wave_in = 12'($urandom);
            rst = ($urandom_range(0, 1500) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/env_gen.md
# env_gen

ADSR envelope generator for one SID voice. It sits downstream of the oscillator accumulator stage and shares that stage's `control` byte, using only the gate bit. It produces an 8-bit envelope level and scales the voice's 12-bit selected waveform by it. The result is a 20-bit amplitude sample for the voice mixer. Clocked at the 1 MHz SID rate.

## Interface
- No parameters; all rates come from a fixed table in the package.
- `clk`  in  1  system clock, 1 MHz SID cycle
- `rst`  in  1  synchronous reset, active-high
- `control`  in  8  voice control byte; bit 0 = gate; all other bits ignored
- `attack_decay`  in  8  [7:4] attack rate index, [3:0] decay rate index
- `sustain_release`  in  8  [7:4] sustain level, [3:0] release rate index
- `wave_in`  in  12  selected waveform sample, unsigned
- `env_out`  out  8  current envelope level
- `env_state`  out  2  current ADSR state (package enum)
- `amp_out`  out  20  registered `wave_in * env_out`, unsigned

## Operation
- States: `RELEASE` (reset state), `ATTACK`, `DECAY_SUSTAIN`.
- Gate edge detection uses a registered copy of gate.
  - Rising edge: go to `ATTACK` from any state.
  - Falling edge: go to `RELEASE` from any state.
- Rate counter (15 bit):
  - Period P is taken from the 16-entry table: 9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251.
  - The counter counts 0..P-1 and emits a rate tick when it wraps, i.e. one tick every P cycles.
  - It clears to 0 on every state change.
  - The rate index is the attack, decay or release nibble according to the current state.
- `ATTACK`:
  - Each rate tick does env+1.
  - When env reaches 0xFF, go to `DECAY_SUSTAIN` in the same cycle. env never wraps.
- `DECAY_SUSTAIN`:
  - Sustain target is {S,S}, the nibble replicated (e.g. S=0xA gives 0xAA).
  - While env > target, each step does env-1.
  - At env == target the level holds.
  - If the target is raised above env, env holds and never increases.
  - If the target is lowered, decay resumes.
- `RELEASE`: each step does env-1 and holds at 0.
- Step definition:
  - In `ATTACK`, every rate tick is a step.
  - In decay and release, a step is defined by the exponential divider (see Configuration).
- Simultaneous events: a gate edge and a rate tick in the same cycle means the edge wins. env is unchanged that cycle and the counters clear.
- Register writes to the rate or sustain fields take effect on the next cycle. The rate counter is not cleared on such writes.
  - If the new P is at or below the current count, the counter continues to 0x7FFF, wraps, and then compares again. This matches the real chip's long-delay behaviour.
- Multiply: `amp_out` = `wave_in` × `env_out` as a 12×8 unsigned product, 20 bits wide, no truncation.

## Timing
- Reset values:
  - env_out = 0, env_state = RELEASE, amp_out = 0.
  - Rate and exponential counters = 0, gate history = 0.
- Gate rising edge sampled at cycle N:
  - env_state = ATTACK is visible at N+1.
  - The first env increment is visible at N+P (counter restarts at N+1).
- env_out is registered. amp_out has one cycle of latency from env_out and wave_in.
- Reset asserted mid-envelope forces all reset values on the next edge, regardless of gate. After reset release with gate already high, no rising edge is seen and the state stays `RELEASE`.

## Configuration
- `ENV_EXP_DECAY_EN` defined: decay and release steps are divided by an exponential counter.
  - The divisor is selected from the current env: ≥94 → 1; 55..93 → 2; 27..54 → 4; 15..26 → 8; 7..14 → 16; 1..6 → 30.
  - A step occurs when the exponential counter reaches the divisor; the counter then clears.
  - The counter also clears on state change and on entering `ATTACK`.
- Undefined: linear mode. Every rate tick is a step in all states, and the exponential counter logic is absent.

## Structure
- Package `sid_pkg` holds:
  - the `adsr_state_t` enum (2 bit);
  - the 16-entry `RATE_PERIOD` constant array (15 bit);
  - the exponential threshold and divisor constants;
  - the `sustain_level()` function that replicates the nibble.
- One sub-module, `env_rate_cnt`:
  - inputs: the 4-bit rate index and a clear;
  - output: a tick pulse.
  - It contains the 15-bit counter and the period lookup.

## Test plan
- Attack: rst, then gate=1 with attack=0 → env increments every 9 cycles and reaches 0xFF 2295 cycles after state becomes ATTACK. State becomes DECAY_SUSTAIN in that cycle.
- Decay to sustain: decay=0, S=0x8, linear build → env falls from 0xFF to 0x88 in 119 steps of 9 cycles, then holds at 0x88 indefinitely.
- Release: gate 1→0 at env=0x88, release=1, linear build → env reaches 0 after 136×32 cycles and holds at 0. The env==0 hold must be checked for no wrap.
- Exponential build (`ENV_EXP_DECAY_EN`), release=0 from 0xFF:
  - first step interval 9 cycles (env ≥94);
  - interval 18 cycles at env=60;
  - interval 270 cycles at env=3.
- Gate retrigger: gate falls at env=0x40, rises 100 cycles later → ATTACK resumes from the current env (not 0). A gate edge coincident with a rate tick leaves env unchanged.
- Multiply and reset: wave_in=0xFFF with env=0xFF → amp_out=0xFEF01 one cycle later. rst pulse mid-attack → env_out=0, amp_out=0, state RELEASE on the next edge.
